// File: rtl/div_seq_param.sv
// Sequential non-restoring divider: one quotient bit per cycle, signed or unsigned,
// valid/ready on both sides, divide-by-zero reported through exception.
module div_seq_param #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;

    logic             op_signed;
    logic             dd_neg;
    logic             dv_neg;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] a_rem;

    assign op_signed = SIGNED_EN && in_signed;
    assign dd_neg    = op_signed && dividend[WIDTH-1];
    assign dv_neg    = op_signed && divisor[WIDTH-1];
    assign d_ext     = {1'b0, d_q};

    // The add/subtract choice uses the sign of A before the shift.
    assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign a_step  = a_q[WIDTH] ? (a_shift + d_ext) : (a_shift - d_ext);
    assign a_rem   = a_q[WIDTH] ? (a_q[WIDTH-1:0] + d_q) : a_q[WIDTH-1:0];

    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        exc_d   = exc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        exc_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        q_d     = dd_neg ? -dividend : dividend;
                        d_d     = dv_neg ? -divisor : divisor;
                        a_d     = '0;
                        cnt_d   = '0;
                        qneg_d  = dd_neg ^ dv_neg;
                        rneg_d  = dd_neg;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                a_d   = a_step;
                q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quot_d  = qneg_q ? -q_q : q_q;
                rem_d   = rneg_q ? -a_rem : a_rem;
                exc_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            exc_q   <= exc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign exception = exc_q;

endmodule
